// File: rtl/hack_pkg.sv
// Shared constants for the Hack RAM hierarchy.
//   HACK_WIDTH  : datapath word width
//   RAM8_DEPTH  : words per RAM8 block
//   RAM8_ADDR_W : address bits for a RAM8 block
//   WORD_RESET  : value every word register takes on reset
package hack_pkg;
    localparam int unsigned HACK_WIDTH  = 16;
    localparam int unsigned RAM8_DEPTH  = 8;
    localparam int unsigned RAM8_ADDR_W = 3;
    localparam logic [15:0] WORD_RESET  = 16'h0000;
endpackage

// File: rtl/ram8_dmux_if.sv
// Bus bundle for a RAM8 block.
//   in      : write data
//   load    : level-sampled write strobe
//   address : word select for both the write and the read path
//   out     : contents of the addressed word
// master drives in/load/address, slave drives out.
interface ram8_dmux_if
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH  = HACK_WIDTH,
    parameter int unsigned ADDR_W = RAM8_ADDR_W
);
    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  out;

    modport master (output in, output load, output address, input out);
    modport slave  (input in, input load, input address, output out);
endinterface

// File: rtl/dmux8way_gate.sv
// 1-to-8 demultiplexer: routes i_in to the output selected by i_sel,
// all other outputs are 0. Reused by the RAM64 load router.
//   i_in       : bit to route
//   i_sel      : 3-bit output select
//   o_a .. o_h : outputs for sel = 0 .. 7
module dmux8way_gate (
    input  logic       i_in,
    input  logic [2:0] i_sel,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d,
    output logic       o_e,
    output logic       o_f,
    output logic       o_g,
    output logic       o_h
);
    always_comb begin
        o_a = i_in & (i_sel == 3'd0);
        o_b = i_in & (i_sel == 3'd1);
        o_c = i_in & (i_sel == 3'd2);
        o_d = i_in & (i_sel == 3'd3);
        o_e = i_in & (i_sel == 3'd4);
        o_f = i_in & (i_sel == 3'd5);
        o_g = i_in & (i_sel == 3'd6);
        o_h = i_in & (i_sel == 3'd7);
    end
endmodule

// File: rtl/mux16_gate.sv
// 2-to-1 word multiplexer primitive.
//   i_a   : selected when i_sel = 0
//   i_b   : selected when i_sel = 1
//   i_sel : select
//   o_out : selected word
module mux16_gate
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = HACK_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_out
);
    assign o_out = i_sel ? i_b : i_a;
endmodule

// File: rtl/mux8way16_gate.sv
// 8-to-1 word multiplexer built as a three-level tree of mux16_gate.
//   i_a .. i_h : words for sel = 0 .. 7
//   i_sel      : 3-bit select
//   o_out      : selected word
module mux8way16_gate
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = HACK_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_e,
    input  logic [WIDTH-1:0] i_f,
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_h,
    input  logic [2:0]       i_sel,
    output logic [WIDTH-1:0] o_out
);
    logic [WIDTH-1:0] w_ab, w_cd, w_ef, w_gh, w_abcd, w_efgh;

    // Level 1 picks on sel[0], level 2 on sel[1], level 3 on sel[2].
    mux16_gate #(.WIDTH(WIDTH)) u_ab (.i_a(i_a), .i_b(i_b), .i_sel(i_sel[0]), .o_out(w_ab));
    mux16_gate #(.WIDTH(WIDTH)) u_cd (.i_a(i_c), .i_b(i_d), .i_sel(i_sel[0]), .o_out(w_cd));
    mux16_gate #(.WIDTH(WIDTH)) u_ef (.i_a(i_e), .i_b(i_f), .i_sel(i_sel[0]), .o_out(w_ef));
    mux16_gate #(.WIDTH(WIDTH)) u_gh (.i_a(i_g), .i_b(i_h), .i_sel(i_sel[0]), .o_out(w_gh));

    mux16_gate #(.WIDTH(WIDTH)) u_abcd (.i_a(w_ab), .i_b(w_cd), .i_sel(i_sel[1]), .o_out(w_abcd));
    mux16_gate #(.WIDTH(WIDTH)) u_efgh (.i_a(w_ef), .i_b(w_gh), .i_sel(i_sel[1]), .o_out(w_efgh));

    mux16_gate #(.WIDTH(WIDTH)) u_out (.i_a(w_abcd), .i_b(w_efgh), .i_sel(i_sel[2]), .o_out(o_out));
endmodule

// File: rtl/register16.sv
// Word register with load enable and synchronous active-low clear.
//   clk    : clock
//   rst_n  : synchronous clear, active-low, overrides i_load
//   i_load : capture i_d on the rising edge
//   i_d    : data in
//   o_q    : stored word
module register16
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = HACK_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= WIDTH'(WORD_RESET);
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/ram8_dmux.sv
// Eight-word register memory, lowest level of the Hack RAM hierarchy.
// The load strobe is demuxed to one of eight word registers; the
// addressed word is returned combinationally, so a read during a write
// shows the old value until the edge.
//   clk   : clock, all updates on the rising edge
//   rst_n : synchronous active-low clear of all words (overrides load)
//   bus   : slave side of ram8_dmux_if (in, load, address -> out)
module ram8_dmux
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = HACK_WIDTH,
    parameter int unsigned DEPTH = RAM8_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    ram8_dmux_if.slave   bus
);
    logic [DEPTH-1:0] w_load_i;
    logic [WIDTH-1:0] w_word [DEPTH];

    dmux8way_gate u_dmux (
        .i_in  (bus.load),
        .i_sel (bus.address),
        .o_a   (w_load_i[0]),
        .o_b   (w_load_i[1]),
        .o_c   (w_load_i[2]),
        .o_d   (w_load_i[3]),
        .o_e   (w_load_i[4]),
        .o_f   (w_load_i[5]),
        .o_g   (w_load_i[6]),
        .o_h   (w_load_i[7])
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        register16 #(.WIDTH(WIDTH)) u_reg (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_load_i[i]),
            .i_d    (bus.in),
            .o_q    (w_word[i])
        );
    end

    mux8way16_gate #(.WIDTH(WIDTH)) u_mux (
        .i_a   (w_word[0]),
        .i_b   (w_word[1]),
        .i_c   (w_word[2]),
        .i_d   (w_word[3]),
        .i_e   (w_word[4]),
        .i_f   (w_word[5]),
        .i_g   (w_word[6]),
        .i_h   (w_word[7]),
        .i_sel (bus.address),
        .o_out (bus.out)
    );
endmodule

// File: tb/tb_ram8_dmux.sv
// Directed self-checking bench for ram8_dmux.
module tb_ram8_dmux;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ram8_dmux_if #(.WIDTH(16), .ADDR_W(3)) bus ();

    ram8_dmux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load = 1'b1;
        bus.in = 16'hFFFF;
        bus.address = 3'd0;
        step();
        step();
        rst_n = 1'b1;
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            n_checks++;
            if (bus.out !== 16'h0000) begin
                $display("FAIL reset addr=%0d got=%h exp=%h", a, bus.out, 16'h0000);
                n_errors++;
            end
        end
    endtask

    task automatic test_write_read_all();
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            bus.in = 16'h1000 + 16'(a);
            bus.load = 1'b1;
            step();
        end
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            n_checks++;
            if (bus.out !== 16'h1000 + 16'(a)) begin
                $display("FAIL write_all addr=%0d got=%h exp=%h", a, bus.out, 16'h1000 + 16'(a));
                n_errors++;
            end
        end
    endtask

    task automatic test_read_during_write();
        bus.address = 3'd3;
        bus.in = 16'h1234;
        bus.load = 1'b1;
        step();
        bus.in = 16'hABCD;
        #1;
        n_checks++;
        if (bus.out !== 16'h1234) begin
            $display("FAIL rdw_before got=%h exp=%h", bus.out, 16'h1234);
            n_errors++;
        end
        step();
        bus.load = 1'b0;
        #1;
        n_checks++;
        if (bus.out !== 16'hABCD) begin
            $display("FAIL rdw_after got=%h exp=%h", bus.out, 16'hABCD);
            n_errors++;
        end
        // Neighbours of word 3 keep their values.
        bus.address = 3'd2;
        #1;
        n_checks++;
        if (bus.out !== 16'h1002) begin
            $display("FAIL rdw_neighbour2 got=%h exp=%h", bus.out, 16'h1002);
            n_errors++;
        end
        bus.address = 3'd4;
        #1;
        n_checks++;
        if (bus.out !== 16'h1004) begin
            $display("FAIL rdw_neighbour4 got=%h exp=%h", bus.out, 16'h1004);
            n_errors++;
        end
    endtask

    task automatic test_load_low();
        bus.address = 3'd5;
        bus.in = 16'h5555;
        bus.load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (bus.out !== 16'h1005) begin
                $display("FAIL load_low cycle=%0d got=%h exp=%h", c, bus.out, 16'h1005);
                n_errors++;
            end
        end
    endtask

    task automatic test_reset_vs_load();
        bus.address = 3'd7;
        bus.in = 16'hAAAA;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        #1;
        n_checks++;
        if (bus.out !== 16'hAAAA) begin
            $display("FAIL rst_load_pre got=%h exp=%h", bus.out, 16'hAAAA);
            n_errors++;
        end
        rst_n = 1'b0;
        bus.load = 1'b1;
        bus.in = 16'h5555;
        step();
        rst_n = 1'b1;
        bus.load = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            n_checks++;
            if (bus.out !== 16'h0000) begin
                $display("FAIL rst_load addr=%0d got=%h exp=%h", a, bus.out, 16'h0000);
                n_errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_mem [8];
        for (int a = 0; a < 8; a++) exp_mem[a] = 16'h0000;
        exp_mem[2] = 16'hF0F0;
        exp_mem[6] = 16'h00FF;

        bus.load = 1'b1;
        bus.address = 3'd2;
        bus.in = 16'h0F0F;
        step();
        bus.in = 16'hF0F0;
        step();
        bus.address = 3'd6;
        bus.in = 16'h00FF;
        step();
        bus.load = 1'b0;
        bus.in = 16'h0000;
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            n_checks++;
            if (bus.out !== exp_mem[a]) begin
                $display("FAIL back_to_back addr=%0d got=%h exp=%h", a, bus.out, exp_mem[a]);
                n_errors++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        bus.load = 1'b0;
        bus.in = 16'h0000;
        bus.address = 3'd0;
        #1;
        test_reset();
        test_write_read_all();
        test_read_during_write();
        test_load_low();
        test_reset_vs_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
